// File: rtl/transform_pkg.sv
// ---------------------------------------------------------------------------
// transform_pkg
// Shared definitions for the object-transform parameter controller:
//   - parameter index constants (Tx..Sz) and the parameter count
//   - edit FSM state encoding
//   - default rotation wrap modulus
//   - step_value(): one saturating (T/S) or wrapping (R) edit step
// ---------------------------------------------------------------------------
package transform_pkg;

   localparam int TX_IDX     = 32'd0;
   localparam int TY_IDX     = 32'd1;
   localparam int TZ_IDX     = 32'd2;
   localparam int RX_IDX     = 32'd3;
   localparam int RY_IDX     = 32'd4;
   localparam int RZ_IDX     = 32'd5;
   localparam int SX_IDX     = 32'd6;
   localparam int SY_IDX     = 32'd7;
   localparam int SZ_IDX     = 32'd8;
   localparam int NUM_PARAMS = 32'd9;

   localparam int ROT_MOD_DEFAULT = 32'd360;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      REPEAT   = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // One edit step of size amt. dir=1 increments, dir=0 decrements.
   // Non-rotation values clamp to [0, max_val]; rotation values are kept
   // in [0, rot_mod-1] and wrap modulo rot_mod (amt must be < rot_mod).
   function automatic logic [31:0] step_value(
      input logic [31:0] val,
      input logic        dir,
      input logic        is_rot,
      input logic [31:0] amt,
      input logic [31:0] max_val,
      input logic [31:0] rot_mod
   );
      logic [31:0] res;
      if (is_rot) begin
         if (dir) begin
            res = ((val + amt) >= rot_mod) ? (val + amt - rot_mod) : (val + amt);
         end else begin
            res = (val < amt) ? (val + rot_mod - amt) : (val - amt);
         end
      end else begin
         if (dir) begin
            res = (val > (max_val - amt)) ? max_val : (val + amt);
         end else begin
            res = (val < amt) ? 32'd0 : (val - amt);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// ---------------------------------------------------------------------------
// hold_repeat_timer
// Loadable down-counter used for the hold delay and the auto-repeat period.
// Ports:
//   Clock      in  system clock
//   resetn     in  asynchronous active-high reset (clears the count)
//   load       in  load load_value this cycle (has priority over enable)
//   enable     in  decrement by one, stopping at zero
//   load_value in  W-bit reload value
//   zero       out count is zero
// ---------------------------------------------------------------------------
module hold_repeat_timer #(
   parameter int W = 32
) (
   input  logic         Clock,
   input  logic         resetn,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Count register: load, decrement toward zero, or hold.
   always_ff @(posedge Clock or posedge resetn) begin
      if (resetn) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (enable && (count_r != {W{1'b0}})) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/transform_param_ctrl.sv
// ---------------------------------------------------------------------------
// transform_param_ctrl
// Owns the nine transform parameters (Tx..Tz, Rx..Rz, Sx..Sz) and edits the
// selected one from the up/down buttons with hold-to-repeat.
// Ports:
//   Clock                   in   system clock
//   resetn                  in   asynchronous reset, ACTIVE HIGH
//   select[3:0]             in   parameter index 0..8 (9..15 invalid)
//   switchUp / switchDown   in   level increment / decrement requests
//   Tx..Sz[WIDTH-1:0]       out  registered parameter values
//   TxChanging..SzChanging  out  registered "being edited" flags
//   busy                    out  registered OR of all Changing flags
// Build option: define ACCEL_EN to make repeat steps grow to 8 once eight
// steps have been applied in the repeat phase.
// ---------------------------------------------------------------------------
module transform_param_ctrl
   import transform_pkg::*;
#(
   parameter int WIDTH         = 10,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000,
   parameter int SCALE_INIT    = 100,
   parameter int ROT_MOD       = ROT_MOD_DEFAULT
) (
   input  logic             Clock,
   input  logic             resetn,
   input  logic [3:0]       select,
   input  logic             switchUp,
   input  logic             switchDown,
   output logic [WIDTH-1:0] Tx, Ty, Tz,
   output logic [WIDTH-1:0] Rx, Ry, Rz,
   output logic [WIDTH-1:0] Sx, Sy, Sz,
   output logic             TxChanging, TyChanging, TzChanging,
   output logic             RxChanging, RyChanging, RzChanging,
   output logic             SxChanging, SyChanging, SzChanging,
   output logic             busy
);

   localparam logic [31:0] MAX_VAL     = 32'((64'd1 << WIDTH) - 64'd1);
   localparam logic [31:0] ROT_MOD_U   = 32'(ROT_MOD);
   localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] REPEAT_LOAD = 32'(REPEAT_CYCLES - 1);

   state_t                  state_r, next_state_s;
   logic [3:0]              sel_q_r, sel_next_s, step_idx_s;
   logic [WIDTH-1:0]        param_r [NUM_PARAMS];
   logic [NUM_PARAMS-1:0]   changing_r, changing_next_s;
   logic                    busy_r;
   logic                    req_valid_s, sel_match_s, do_step_s;
   logic                    timer_load_s, timer_en_s, timer_zero_s;
   logic [31:0]             timer_load_val_s, step_amt_s;

   assign req_valid_s = (switchUp ^ switchDown) && (select <= 4'd8);
   assign sel_match_s = (select == sel_q_r);

   hold_repeat_timer #(.W(32)) u_timer (
      .Clock      (Clock),
      .resetn     (resetn),
      .load       (timer_load_s),
      .enable     (timer_en_s),
      .load_value (timer_load_val_s),
      .zero       (timer_zero_s)
   );

`ifdef ACCEL_EN
   logic [3:0] accel_cnt_r;

   assign step_amt_s = ((state_r == REPEAT) && (accel_cnt_r == 4'd8)) ? 32'd8 : 32'd1;

   // Counts steps that lead into or occur in REPEAT; cleared whenever the
   // FSM is not staying in REPEAT.
   always_ff @(posedge Clock or posedge resetn) begin
      if (resetn) begin
         accel_cnt_r <= 4'd0;
      end else if (next_state_s != REPEAT) begin
         accel_cnt_r <= 4'd0;
      end else if (do_step_s && (accel_cnt_r != 4'd8)) begin
         accel_cnt_r <= accel_cnt_r + 4'd1;
      end else begin
         accel_cnt_r <= accel_cnt_r;
      end
   end
`else
   assign step_amt_s = 32'd1;
`endif

   // Next-state, step and timer control for the edit FSM.
   always_comb begin
      next_state_s     = state_r;
      do_step_s        = 1'b0;
      timer_load_s     = 1'b0;
      timer_en_s       = 1'b0;
      timer_load_val_s = 32'd0;
      step_idx_s       = sel_q_r;
      sel_next_s       = sel_q_r;
      case (state_r)
         IDLE: begin
            if (req_valid_s) begin
               do_step_s        = 1'b1;
               step_idx_s       = select;
               sel_next_s       = select;
               timer_load_s     = 1'b1;
               timer_load_val_s = HOLD_LOAD;
               next_state_s     = HOLD;
            end else begin
               next_state_s     = IDLE;
            end
         end
         HOLD, REPEAT: begin
            // A dropped request or a different (possibly invalid) select
            // ends the edit without a final step.
            if (!req_valid_s || !sel_match_s) begin
               next_state_s     = WAIT_REL;
            end else if (timer_zero_s) begin
               do_step_s        = 1'b1;
               timer_load_s     = 1'b1;
               timer_load_val_s = REPEAT_LOAD;
               next_state_s     = REPEAT;
            end else begin
               timer_en_s       = 1'b1;
            end
         end
         WAIT_REL: begin
            if (!switchUp && !switchDown) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = WAIT_REL;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Changing flags for the next cycle: one-hot on the edited parameter.
   always_comb begin
      changing_next_s = {NUM_PARAMS{1'b0}};
      for (int i = 0; i < NUM_PARAMS; i++) begin
         if (((next_state_s == HOLD) || (next_state_s == REPEAT)) && (sel_next_s == 4'(i))) begin
            changing_next_s[i] = 1'b1;
         end else begin
            changing_next_s[i] = 1'b0;
         end
      end
   end

   // FSM state, latched select, Changing flags and busy.
   always_ff @(posedge Clock or posedge resetn) begin
      if (resetn) begin
         state_r    <= IDLE;
         sel_q_r    <= 4'd0;
         changing_r <= {NUM_PARAMS{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         sel_q_r    <= sel_next_s;
         changing_r <= changing_next_s;
         busy_r     <= |changing_next_s;
      end
   end

   // Parameter registers; only the stepped one changes.
   always_ff @(posedge Clock or posedge resetn) begin
      if (resetn) begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            param_r[i] <= (i >= SX_IDX) ? WIDTH'(SCALE_INIT) : {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (do_step_s && (step_idx_s == 4'(i))) begin
               param_r[i] <= WIDTH'(step_value(32'(param_r[i]), switchUp,
                                               (i >= RX_IDX) && (i <= RZ_IDX),
                                               step_amt_s, MAX_VAL, ROT_MOD_U));
            end else begin
               param_r[i] <= param_r[i];
            end
         end
      end
   end

   assign Tx = param_r[TX_IDX];
   assign Ty = param_r[TY_IDX];
   assign Tz = param_r[TZ_IDX];
   assign Rx = param_r[RX_IDX];
   assign Ry = param_r[RY_IDX];
   assign Rz = param_r[RZ_IDX];
   assign Sx = param_r[SX_IDX];
   assign Sy = param_r[SY_IDX];
   assign Sz = param_r[SZ_IDX];

   assign TxChanging = changing_r[TX_IDX];
   assign TyChanging = changing_r[TY_IDX];
   assign TzChanging = changing_r[TZ_IDX];
   assign RxChanging = changing_r[RX_IDX];
   assign RyChanging = changing_r[RY_IDX];
   assign RzChanging = changing_r[RZ_IDX];
   assign SxChanging = changing_r[SX_IDX];
   assign SyChanging = changing_r[SY_IDX];
   assign SzChanging = changing_r[SZ_IDX];

   assign busy = busy_r;

endmodule

// File: doc/transform_param_ctrl.md
Name: transform_param_ctrl

Overview:
Owns the nine object-transform parameter registers: translation Tx/Ty/Tz, rotation Rx/Ry/Rz and scale Sx/Sy/Sz.
- User up/down buttons edit the selected parameter, with hold-to-repeat.
- Drives the parameter values and per-parameter Changing flags consumed by the transform datapath and the hex display selector.
- Sits between the board switches and the renderer.

Parameters:
WIDTH, 10, bit width of every parameter register.
HOLD_CYCLES, 25000000, cycles a button must stay held after the first step before auto-repeat starts.
REPEAT_CYCLES, 5000000, cycles between auto-repeat steps.
SCALE_INIT, 100, reset value of Sx/Sy/Sz.
ROT_MOD, 360, rotation wrap modulus; must be <= 2^WIDTH.

Ports:
Clock  in  1  system clock; all state on its rising edge.
resetn  in  1  asynchronous, active-high reset (high = reset, despite the name).
select  in  4  parameter index: 0=Tx 1=Ty 2=Tz 3=Rx 4=Ry 5=Rz 6=Sx 7=Sy 8=Sz; 9-15 invalid.
switchUp  in  1  increment request, level.
switchDown  in  1  decrement request, level.
Tx,Ty,Tz,Rx,Ry,Rz,Sx,Sy,Sz  out  WIDTH each  parameter values, registered.
TxChanging..SzChanging  out  1 each  high while that parameter is being edited.
busy  out  1  OR of all Changing flags.

Behaviour:
- Reset (async): T*=0, R*=0, S*=SCALE_INIT, all Changing=0, busy=0, FSM=IDLE, timer=0.
- Request valid when (switchUp XOR switchDown) and select<=8. Both high, or neither high, means no request.
- FSM states:
  - IDLE: on a valid request, apply one step at this edge (value visible next cycle), latch select into sel_q, load timer=HOLD_CYCLES-1, go to HOLD.
  - HOLD: timer decrements each cycle. At timer==0 with the request still valid, apply a step, load timer=REPEAT_CYCLES-1, go to REPEAT.
  - REPEAT: at timer==0, apply a step and reload the timer.
  - HOLD and REPEAT → WAIT_REL if the request drops or select≠sel_q. No step is applied on that edge.
  - WAIT_REL: → IDLE once switchUp=switchDown=0. A select change therefore needs a fresh press.
- Changing[sel_q]=1 in HOLD and REPEAT only; all flags are registered. busy follows them.
- Step arithmetic (step size 1):
  - T and S saturate at 0 and 2^WIDTH-1.
  - R wraps: ROT_MOD-1 + 1 → 0, and 0 - 1 → ROT_MOD-1.
- Direction is sampled on every step. Swapping switchUp to switchDown without a both-high or neither-high cycle in between reverses the direction without leaving REPEAT.
- Invalid select (9-15): ignored in IDLE. If seen in HOLD/REPEAT it counts as a select change.
- Reset mid-hold: everything returns to reset values immediately; no partial step.

Optional Feature:
ACCEL_EN
- Defined: counts steps applied in REPEAT, saturating at 8. Once the count reaches 8, each repeat step is 8 instead of 1, with the same saturate/wrap rules (for R, modulo ROT_MOD). The count clears on leaving REPEAT.
- Undefined: step is always 1 and no counter exists.

Decomposition:
Package transform_pkg:
- Index constants TX_IDX=0 … SZ_IDX=8, NUM_PARAMS=9.
- FSM state enum {IDLE,HOLD,REPEAT,WAIT_REL}.
- ROT_MOD default.
- Step function step_value(val, dir, is_rot, amt).

Sub-module hold_repeat_timer:
- Loadable down-counter with load value, enable and zero flag.
- Instantiated once.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2, WIDTH=10):
1. After reset → Tx=0, Rz=0, Sy=100, all Changing=0. Pulse switchUp 1 cycle with select=0 → Tx=1 next cycle, TxChanging high 1 cycle, back to IDLE after release.
2. select=3, hold switchUp 10 cycles → Rx steps at cycles 0,4,6,8 giving Rx=4. RxChanging high from cycle 1 until release.
3. Rx=0, pulse switchDown → Rx=359. Then Rx=359, pulse switchUp → Rx=0.
4. Tz=0, pulse switchDown → Tz stays 0. Sx=1023, pulse switchUp → Sx stays 1023.
5. Hold switchUp with select=6, change select to 7 mid-HOLD → no more steps, Sy unchanged, FSM stays WAIT_REL until the button is released. select=12 pressed → no change at all.
6. Both switches high → no step. Assert resetn mid-REPEAT → all outputs at reset values the same cycle. With ACCEL_EN, hold 30 cycles on Ty → steps +1 ×9, then +8.
